// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port among ICache, DCache and uncached requesters.
// Independent read/write FSMs with fixed priority and ordering hazard guards.
module mem_bus_arbiter #(
  parameter int LINE_WORD = 4
) (
  input  logic                   clk,
  input  logic                   resetn,

  input  logic                   ic_rd_req,
  input  logic [31:0]            ic_rd_addr,
  output logic                   ic_rd_rdy,
  output logic                   ic_ret_valid,
  output logic [LINE_WORD*32-1:0] ic_ret_data,

  input  logic                   dc_rd_req,
  input  logic [31:0]            dc_rd_addr,
  output logic                   dc_rd_rdy,
  output logic                   dc_ret_valid,
  output logic [LINE_WORD*32-1:0] dc_ret_data,

  input  logic                   dc_wr_req,
  input  logic [31:0]            dc_wr_addr,
  input  logic [LINE_WORD*32-1:0] dc_wr_data,
  output logic                   dc_wr_rdy,
  output logic                   dc_wr_valid,

  input  logic                   uc_rd_req,
  input  logic [31:0]            uc_rd_addr,
  input  logic [1:0]             uc_rd_size,
  output logic                   uc_rd_rdy,
  output logic                   uc_ret_valid,
  output logic [31:0]            uc_ret_data,

  input  logic                   uc_wr_req,
  input  logic [31:0]            uc_wr_addr,
  input  logic [31:0]            uc_wr_data,
  input  logic [3:0]             uc_wr_wstrb,
  output logic                   uc_wr_rdy,
  output logic                   uc_wr_valid,

  output logic                   m_rd_req,
  output logic [31:0]            m_rd_addr,
  output logic [7:0]             m_rd_len,
  output logic [1:0]             m_rd_size,
  input  logic                   m_rd_rdy,
  input  logic                   m_ret_valid,
  input  logic [LINE_WORD*32-1:0] m_ret_data,

  output logic                   m_wr_req,
  output logic [31:0]            m_wr_addr,
  output logic [7:0]             m_wr_len,
  output logic [1:0]             m_wr_size,
  output logic [LINE_WORD*32-1:0] m_wr_data,
  output logic [3:0]             m_wr_wstrb,
  input  logic                   m_wr_rdy,
  input  logic                   m_wr_valid
);

  localparam int          LINE_W   = LINE_WORD * 32;
  localparam int          OFF      = $clog2(LINE_WORD * 4);
  localparam logic [7:0]  LINE_LEN = 8'(LINE_WORD - 1);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_state_t;
  typedef enum logic [1:0] {RO_IC, RO_DC, RO_UC} rd_own_t;
  typedef enum logic       {WO_DC, WO_UC} wr_own_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  rd_own_t   rd_own;
  wr_own_t   wr_own;

  logic rd_grant_ic, rd_grant_dc, rd_grant_uc;
  logic wr_grant_dc, wr_grant_uc;
  logic wr_busy, uc_rd_block, dc_rd_block;

  // Ordering guards: an uncached read must not pass an outstanding uncached
  // write, and a DCache refill must not pass a writeback of the same line.
  assign wr_busy     = (wr_state != W_IDLE);
  assign uc_rd_block = wr_busy && (wr_own == WO_UC);
  assign dc_rd_block = wr_busy && (wr_own == WO_DC) &&
                       (dc_rd_addr[31:OFF] == m_wr_addr[31:OFF]);

  always_comb begin
    rd_next     = rd_state;
    rd_grant_ic = 1'b0;
    rd_grant_dc = 1'b0;
    rd_grant_uc = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (resetn) begin
          if (dc_rd_req && !dc_rd_block) begin
            rd_grant_dc = 1'b1;
            rd_next     = R_REQ;
          end else if (uc_rd_req && !uc_rd_block) begin
            rd_grant_uc = 1'b1;
            rd_next     = R_REQ;
          end else if (ic_rd_req) begin
            rd_grant_ic = 1'b1;
            rd_next     = R_REQ;
          end
        end
      end
      R_REQ:   if (m_rd_rdy) rd_next = R_WAIT;
      R_WAIT:  if (m_ret_valid) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_next     = wr_state;
    wr_grant_dc = 1'b0;
    wr_grant_uc = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (resetn) begin
          if (dc_wr_req) begin
            wr_grant_dc = 1'b1;
            wr_next     = W_REQ;
          end else if (uc_wr_req) begin
            wr_grant_uc = 1'b1;
            wr_next     = W_REQ;
          end
        end
      end
      W_REQ:   if (m_wr_rdy) wr_next = W_WAIT;
      W_WAIT:  if (m_wr_valid) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state  <= R_IDLE;
      rd_own    <= RO_IC;
      m_rd_req  <= 1'b0;
      m_rd_addr <= '0;
      m_rd_len  <= '0;
      m_rd_size <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_grant_dc) begin
        rd_own    <= RO_DC;
        m_rd_req  <= 1'b1;
        m_rd_addr <= dc_rd_addr;
        m_rd_len  <= LINE_LEN;
        m_rd_size <= 2'd2;
      end else if (rd_grant_uc) begin
        rd_own    <= RO_UC;
        m_rd_req  <= 1'b1;
        m_rd_addr <= uc_rd_addr;
        m_rd_len  <= 8'd0;
        m_rd_size <= uc_rd_size;
      end else if (rd_grant_ic) begin
        rd_own    <= RO_IC;
        m_rd_req  <= 1'b1;
        m_rd_addr <= ic_rd_addr;
        m_rd_len  <= LINE_LEN;
        m_rd_size <= 2'd2;
      end else if (rd_state == R_REQ && m_rd_rdy) begin
        m_rd_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state   <= W_IDLE;
      wr_own     <= WO_DC;
      m_wr_req   <= 1'b0;
      m_wr_addr  <= '0;
      m_wr_len   <= '0;
      m_wr_size  <= '0;
      m_wr_data  <= '0;
      m_wr_wstrb <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_grant_dc) begin
        wr_own     <= WO_DC;
        m_wr_req   <= 1'b1;
        m_wr_addr  <= dc_wr_addr;
        m_wr_len   <= LINE_LEN;
        m_wr_size  <= 2'd2;
        m_wr_data  <= dc_wr_data;
        m_wr_wstrb <= 4'hF;
      end else if (wr_grant_uc) begin
        wr_own     <= WO_UC;
        m_wr_req   <= 1'b1;
        m_wr_addr  <= uc_wr_addr;
        m_wr_len   <= 8'd0;
        m_wr_size  <= 2'd2;
        m_wr_data  <= LINE_W'(uc_wr_data);
        m_wr_wstrb <= uc_wr_wstrb;
      end else if (wr_state == W_REQ && m_wr_rdy) begin
        m_wr_req <= 1'b0;
      end
    end
  end

  assign ic_rd_rdy = rd_grant_ic;
  assign dc_rd_rdy = rd_grant_dc;
  assign uc_rd_rdy = rd_grant_uc;
  assign dc_wr_rdy = wr_grant_dc;
  assign uc_wr_rdy = wr_grant_uc;

  // Completion strobes only count while the matching FSM is waiting.
  assign ic_ret_valid = (rd_state == R_WAIT) && m_ret_valid && (rd_own == RO_IC);
  assign dc_ret_valid = (rd_state == R_WAIT) && m_ret_valid && (rd_own == RO_DC);
  assign uc_ret_valid = (rd_state == R_WAIT) && m_ret_valid && (rd_own == RO_UC);
  assign dc_wr_valid  = (wr_state == W_WAIT) && m_wr_valid && (wr_own == WO_DC);
  assign uc_wr_valid  = (wr_state == W_WAIT) && m_wr_valid && (wr_own == WO_UC);

  assign ic_ret_data = m_ret_data;
  assign dc_ret_data = m_ret_data;
  assign uc_ret_data = m_ret_data[31:0];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic resetn;
  logic ic_rd_req; logic [31:0] ic_rd_addr; logic ic_rd_rdy, ic_ret_valid; logic [LW*32-1:0] ic_ret_data;
  logic dc_rd_req; logic [31:0] dc_rd_addr; logic dc_rd_rdy, dc_ret_valid; logic [LW*32-1:0] dc_ret_data;
  logic dc_wr_req; logic [31:0] dc_wr_addr; logic [LW*32-1:0] dc_wr_data; logic dc_wr_rdy, dc_wr_valid;
  logic uc_rd_req; logic [31:0] uc_rd_addr; logic [1:0] uc_rd_size; logic uc_rd_rdy, uc_ret_valid; logic [31:0] uc_ret_data;
  logic uc_wr_req; logic [31:0] uc_wr_addr, uc_wr_data; logic [3:0] uc_wr_wstrb; logic uc_wr_rdy, uc_wr_valid;
  logic m_rd_req; logic [31:0] m_rd_addr; logic [7:0] m_rd_len; logic [1:0] m_rd_size;
  logic m_rd_rdy, m_ret_valid; logic [LW*32-1:0] m_ret_data;
  logic m_wr_req; logic [31:0] m_wr_addr; logic [7:0] m_wr_len; logic [1:0] m_wr_size;
  logic [LW*32-1:0] m_wr_data; logic [3:0] m_wr_wstrb; logic m_wr_rdy, m_wr_valid;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.LINE_WORD(LW)) dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_rdy(dc_wr_rdy), .dc_wr_valid(dc_wr_valid),
    .uc_rd_req(uc_rd_req), .uc_rd_addr(uc_rd_addr), .uc_rd_size(uc_rd_size),
    .uc_rd_rdy(uc_rd_rdy), .uc_ret_valid(uc_ret_valid), .uc_ret_data(uc_ret_data),
    .uc_wr_req(uc_wr_req), .uc_wr_addr(uc_wr_addr), .uc_wr_data(uc_wr_data),
    .uc_wr_wstrb(uc_wr_wstrb), .uc_wr_rdy(uc_wr_rdy), .uc_wr_valid(uc_wr_valid),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len), .m_rd_size(m_rd_size),
    .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_len(m_wr_len), .m_wr_size(m_wr_size),
    .m_wr_data(m_wr_data), .m_wr_wstrb(m_wr_wstrb), .m_wr_rdy(m_wr_rdy), .m_wr_valid(m_wr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_rd_req = 0; ic_rd_addr = 0;
    dc_rd_req = 0; dc_rd_addr = 0;
    dc_wr_req = 0; dc_wr_addr = 0; dc_wr_data = 0;
    uc_rd_req = 0; uc_rd_addr = 0; uc_rd_size = 0;
    uc_wr_req = 0; uc_wr_addr = 0; uc_wr_data = 0; uc_wr_wstrb = 0;
    m_rd_rdy = 0; m_ret_valid = 0; m_ret_data = 0;
    m_wr_rdy = 0; m_wr_valid = 0;
  endtask

  // Entered in the cycle where requester `own` (0=IC,1=DC,2=UC) sees rdy.
  task automatic rd_serve(input string tag, input int own, input logic [31:0] a,
                          input logic [7:0] l, input logic [1:0] s,
                          input logic [127:0] d, input int stall);
    logic [2:0] exp_v;
    exp_v = 3'b001 << own;
    cyc();
    if (own == 0) ic_rd_req = 0; else if (own == 1) dc_rd_req = 0; else uc_rd_req = 0;
    #1;
    chk({tag, "_mreq"}, m_rd_req, 1'b1);
    chk({tag, "_maddr"}, m_rd_addr, a);
    chk({tag, "_mlen"}, m_rd_len, l);
    chk({tag, "_msize"}, m_rd_size, s);
    for (int i = 0; i < stall; i++) begin
      m_ret_valid = 1;
      #1;
      chk({tag, "_early_ret"}, {uc_ret_valid, dc_ret_valid, ic_ret_valid}, 3'b000);
      cyc();
      m_ret_valid = 0;
      #1;
      chk({tag, "_mreq_hold"}, m_rd_req, 1'b1);
    end
    m_rd_rdy = 1;
    cyc();
    m_rd_rdy = 0; m_ret_data = d; m_ret_valid = 1;
    #1;
    chk({tag, "_mreq_drop"}, m_rd_req, 1'b0);
    chk({tag, "_ret_v"}, {uc_ret_valid, dc_ret_valid, ic_ret_valid}, exp_v);
    if (own == 0) chk({tag, "_ret_d"}, ic_ret_data, d);
    else if (own == 1) chk({tag, "_ret_d"}, dc_ret_data, d);
    else chk({tag, "_ret_d"}, uc_ret_data, d[31:0]);
    cyc();
    m_ret_valid = 0;
    #1;
    chk({tag, "_ret_end"}, {uc_ret_valid, dc_ret_valid, ic_ret_valid}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mrd", {m_rd_req, m_rd_addr, m_rd_len, m_rd_size}, 43'd0);
    chk("rst_mwr", {m_wr_req, m_wr_addr, m_wr_len, m_wr_size, m_wr_wstrb}, 47'd0);
    chk("rst_mwdata", m_wr_data, 128'd0);
    resetn = 1;

    // Single ICache refill
    cyc();
    ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0000;
    #1;
    chk("t1_ic_rdy", {dc_rd_rdy, uc_rd_rdy, ic_rd_rdy}, 3'b001);
    rd_serve("t1", 0, 32'h1FC0_0000, 8'd3, 2'd2, 128'h44332211_88776655_CCBBAA99_DDCCBBAA, 1);

    // Three simultaneous reads: DC, then UC, then IC
    cyc();
    ic_rd_req = 1; ic_rd_addr = 32'h0000_0400;
    dc_rd_req = 1; dc_rd_addr = 32'h0000_0800;
    uc_rd_req = 1; uc_rd_addr = 32'hBFD0_0003; uc_rd_size = 2'd0;
    #1;
    chk("t2_dc_first", {dc_rd_rdy, uc_rd_rdy, ic_rd_rdy}, 3'b100);
    rd_serve("t2dc", 1, 32'h0000_0800, 8'd3, 2'd2, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0);
    chk("t2_uc_second", {dc_rd_rdy, uc_rd_rdy, ic_rd_rdy}, 3'b010);
    rd_serve("t2uc", 2, 32'hBFD0_0003, 8'd0, 2'd0, 128'h0_0000_0000_0000_0000_0000_0000_0000_00A5, 0);
    chk("t2_ic_third", {dc_rd_rdy, uc_rd_rdy, ic_rd_rdy}, 3'b001);
    rd_serve("t2ic", 0, 32'h0000_0400, 8'd3, 2'd2, 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004, 0);

    // DC writeback vs same-line / other-line DC refill
    cyc();
    dc_wr_req = 1; dc_wr_addr = 32'h0000_1230;
    dc_wr_data = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    #1;
    chk("t3_wr_rdy", {dc_wr_rdy, uc_wr_rdy}, 2'b10);
    cyc();
    dc_wr_req = 0;
    #1;
    chk("t3_mwr", {m_wr_req, m_wr_addr, m_wr_len, m_wr_size, m_wr_wstrb}, {1'b1, 32'h0000_1230, 8'd3, 2'd2, 4'hF});
    chk("t3_mwdata", m_wr_data, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
    m_wr_rdy = 1;
    cyc();
    m_wr_rdy = 0;
    dc_rd_req = 1; dc_rd_addr = 32'h0000_2000;
    #1;
    chk("t3_other_line", dc_rd_rdy, 1'b1);
    rd_serve("t3a", 1, 32'h0000_2000, 8'd3, 2'd2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);
    dc_rd_req = 1; dc_rd_addr = 32'h0000_1238;
    #1;
    chk("t3_same_line0", dc_rd_rdy, 1'b0);
    cyc();
    #1;
    chk("t3_same_line1", dc_rd_rdy, 1'b0);
    cyc();
    m_wr_valid = 1;
    #1;
    chk("t3_wr_done", {dc_wr_valid, uc_wr_valid}, 2'b10);
    chk("t3_same_line2", dc_rd_rdy, 1'b0);
    cyc();
    m_wr_valid = 0;
    #1;
    chk("t3_wr_done_end", {dc_wr_valid, uc_wr_valid}, 2'b00);
    chk("t3_released", dc_rd_rdy, 1'b1);
    rd_serve("t3b", 1, 32'h0000_1238, 8'd3, 2'd2, 128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0, 0);

    // Uncached write ordering; IC not blocked by the stalled UC read
    cyc();
    uc_wr_req = 1; uc_wr_addr = 32'hBFAF_F000; uc_wr_data = 32'h1122_3344; uc_wr_wstrb = 4'b0011;
    #1;
    chk("t4_uwr_rdy", {dc_wr_rdy, uc_wr_rdy}, 2'b01);
    cyc();
    uc_wr_req = 0;
    #1;
    chk("t4_mwr", {m_wr_req, m_wr_addr, m_wr_len, m_wr_size, m_wr_wstrb}, {1'b1, 32'hBFAF_F000, 8'd0, 2'd2, 4'b0011});
    chk("t4_mwdata", m_wr_data, 128'h0000_0000_0000_0000_0000_0000_1122_3344);
    uc_rd_req = 1; uc_rd_addr = 32'hBFAF_F000; uc_rd_size = 2'd2;
    #1;
    chk("t4_urd_blk0", uc_rd_rdy, 1'b0);
    m_wr_rdy = 1;
    cyc();
    m_wr_rdy = 0;
    ic_rd_req = 1; ic_rd_addr = 32'h0000_0100;
    #1;
    chk("t4_ic_passes", {uc_rd_rdy, ic_rd_rdy}, 2'b01);
    rd_serve("t4ic", 0, 32'h0000_0100, 8'd3, 2'd2, 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003, 0);
    chk("t4_urd_blk1", uc_rd_rdy, 1'b0);
    cyc();
    m_wr_valid = 1;
    #1;
    chk("t4_uwr_done", {dc_wr_valid, uc_wr_valid}, 2'b01);
    chk("t4_urd_blk2", uc_rd_rdy, 1'b0);
    cyc();
    m_wr_valid = 0;
    #1;
    chk("t4_urd_go", uc_rd_rdy, 1'b1);
    rd_serve("t4uc", 2, 32'hBFAF_F000, 8'd0, 2'd2, 128'h0_0000_0000_0000_0000_0000_0000_8765_4321, 0);

    // Concurrent DC writeback and IC refill, independent completions
    cyc();
    dc_wr_req = 1; dc_wr_addr = 32'h0000_3000; dc_wr_data = 128'h77;
    ic_rd_req = 1; ic_rd_addr = 32'h0000_4000;
    #1;
    chk("t5_rdys", {dc_wr_rdy, ic_rd_rdy}, 2'b11);
    cyc();
    dc_wr_req = 0; ic_rd_req = 0;
    #1;
    chk("t5_both_req", {m_rd_req, m_wr_req}, 2'b11);
    chk("t5_addrs", {m_rd_addr, m_wr_addr}, {32'h0000_4000, 32'h0000_3000});
    m_rd_rdy = 1; m_wr_rdy = 1;
    cyc();
    m_rd_rdy = 0; m_wr_rdy = 0; m_wr_valid = 1;
    #1;
    chk("t5_wr_first", {dc_wr_valid, ic_ret_valid}, 2'b10);
    cyc();
    m_wr_valid = 0; m_ret_valid = 1; m_ret_data = 128'h99;
    #1;
    chk("t5_rd_second", {dc_wr_valid, ic_ret_valid}, 2'b01);
    chk("t5_rd_data", ic_ret_data, 128'h99);
    cyc();
    m_ret_valid = 0;

    // Reset in R_WAIT; stale return afterwards ignored
    ic_rd_req = 1; ic_rd_addr = 32'h0000_5000;
    cyc();
    ic_rd_req = 0; m_rd_rdy = 1;
    cyc();
    m_rd_rdy = 0;
    #1;
    resetn = 0; m_ret_valid = 1;
    #1;
    chk("t6_rst_mrd", {m_rd_req, m_rd_addr, m_rd_len, m_rd_size}, 43'd0);
    chk("t6_rst_valids", {ic_ret_valid, dc_ret_valid, uc_ret_valid, dc_wr_valid, uc_wr_valid}, 5'd0);
    m_ret_valid = 0;
    cyc();
    resetn = 1;
    cyc();
    m_ret_valid = 1; m_ret_data = 128'hBAD;
    #1;
    chk("t6_stale_ret", ic_ret_valid, 1'b0);
    cyc();
    m_ret_valid = 0;
    ic_rd_req = 1; ic_rd_addr = 32'h0000_6000;
    #1;
    chk("t6_regrant", ic_rd_rdy, 1'b1);
    rd_serve("t6", 0, 32'h0000_6000, 8'd3, 2'd2, 128'h6666_0000_6666_0001_6666_0002_6666_0003, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one downstream memory port (read channel + write channel) among the ICache line-refill requester, the DCache line-refill/writeback requester and the uncached word requester. It sits between the cache/uncache master ports and the AXI bridge. Independent read and write FSMs allow one read and one write in flight concurrently, with fixed-priority arbitration and ordering guards for uncached and same-line hazards.

## Interface
- LINE_WORD, 4: words per cache line; line data width is LINE_WORD*32
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- ic_rd_req / ic_rd_addr  in  1 / 32  ICache line read request, line-aligned address
- ic_rd_rdy / ic_ret_valid  out  1 / 1  request accepted pulse / data-return pulse
- ic_ret_data  out  LINE_WORD*32  refill line
- dc_rd_req / dc_rd_addr  in  1 / 32  DCache line read
- dc_rd_rdy / dc_ret_valid  out  1 / 1; dc_ret_data  out  LINE_WORD*32
- dc_wr_req / dc_wr_addr / dc_wr_data  in  1 / 32 / LINE_WORD*32  dirty-line writeback
- dc_wr_rdy / dc_wr_valid  out  1 / 1  accepted pulse / write-done pulse
- uc_rd_req / uc_rd_addr / uc_rd_size  in  1 / 32 / 2  uncached read; size 0=byte,1=half,2=word
- uc_rd_rdy / uc_ret_valid  out  1 / 1; uc_ret_data  out  32
- uc_wr_req / uc_wr_addr / uc_wr_data / uc_wr_wstrb  in  1 / 32 / 32 / 4
- uc_wr_rdy / uc_wr_valid  out  1 / 1
- m_rd_req / m_rd_addr / m_rd_len / m_rd_size  out  1 / 32 / 8 / 2  downstream read; len = beats-1
- m_rd_rdy / m_ret_valid  in  1 / 1; m_ret_data  in  LINE_WORD*32
- m_wr_req / m_wr_addr / m_wr_len / m_wr_size / m_wr_data / m_wr_wstrb  out  1 / 32 / 8 / 2 / LINE_WORD*32 / 4
- m_wr_rdy / m_wr_valid  in  1 / 1

## Operation
- Requesters hold req and payload stable until their *_rdy pulse; an accepted request cannot be cancelled (ICache flush must still consume ret_valid).
- Read FSM states R_IDLE, R_REQ, R_WAIT; owner register rd_own ∈ {IC, DC, UC}.
  - R_IDLE: grant highest-priority eligible request, order DC > UC > IC; winner's *_rd_rdy=1 combinationally this cycle; latch addr, len, size, owner; → R_REQ.
  - R_REQ: m_rd_req=1 with latched fields; on m_rd_rdy=1 → R_WAIT.
  - R_WAIT: on m_ret_valid=1 pulse owner's *_ret_valid same cycle; → R_IDLE.
- Write FSM W_IDLE, W_REQ, W_WAIT, owner wr_own ∈ {DC, UC}, priority DC > UC, identical structure; done signalled by m_wr_valid → owner's *_wr_valid.
- Line transfers: len=LINE_WORD-1, size=2, wstrb=4'hF. Uncached: len=0, read size=uc_rd_size, write size=2, wstrb=uc_wr_wstrb, data in bits [31:0], upper bits 0.
- Hazard guards (checked in R_IDLE):
  - UC read ineligible while write FSM ≠ W_IDLE with wr_own=UC (uncached program order).
  - DC read ineligible while write FSM ≠ W_IDLE with wr_own=DC and dc_rd_addr[31:log2(LINE_WORD*4)] equals latched write line address.
  - Blocked requester does not block lower-priority eligible ones.
- ic_ret_data/dc_ret_data = m_ret_data; uc_ret_data = m_ret_data[31:0]; only valid strobes are gated.

## Timing
- Reset (async assert): both FSMs to IDLE, owners to IC/DC; all outputs 0. Reset mid-transaction abandons it; downstream bridge shares resetn.
- Minimum read: req cycle 0 (rdy=1) → m_rd_req cycle 1 → if m_rd_rdy cycle 1, R_WAIT cycle 2; ret_valid forwarded zero-cycle.
- Back-to-back: ret_valid in cycle N returns to IDLE at N+1; next grant earliest N+1.
- Read and write FSMs operate concurrently; m_ret_valid/m_wr_valid only honoured in *_WAIT (ignored otherwise).
- All m_* outputs driven from registers; *_rdy and *_valid are combinational.

## Test plan
- Single IC refill 0x1FC0_0000: rdy cycle 0, m_rd_req cycle 1 len=3 size=2; m_ret_valid with 0x…DDCCBBAA line → ic_ret_valid 1 cycle, data equal.
- IC, DC, UC read requests same cycle: grants DC, then UC, then IC in order; each response routed only to its owner.
- DC writeback line 0x0000_1230 in W_WAIT, DC read 0x0000_1238 → held until m_wr_valid; DC read 0x0000_2000 → granted immediately.
- UC write 0xBFAF_F000 wstrb=4'b0011 outstanding, UC read same address → uc_rd_rdy low until uc_wr_valid; m_wr_wstrb=4'b0011, len=0.
- Concurrent DC writeback and IC read: both m_rd_req and m_wr_req asserted same cycle, completions independent.
- resetn low during R_WAIT: all outputs 0 immediately; after release, new IC request granted normally and stale m_ret_valid in R_IDLE ignored.
